// File: rtl/trigger_event_log.sv
// ----------------------------------------------------------------------------
// trigger_event_log
//
// Purpose
//   Sits downstream of the trigger state machine in the rxclk domain. It
//   timestamps rising edges of the two detect pulses and captures pulse_tof
//   with each edge. The resulting records are queued in a first-word-fall-
//   through FIFO, which the register/DMA side drains with a valid/ready
//   handshake. Both detect pulses are also stretched to a fixed width for the
//   scope and front-panel outputs.
//
// Parameters
//   FIFO_AW         FIFO address width; depth = 2**FIFO_AW records
//   TS_WIDTH        timestamp counter width (8 ns ticks)
//   STRETCH_CYCLES  trig_out_x high time in rxclk cycles (1..65535)
//
// Ports
//   rxclk         in   125 MHz ADC-side clock; the only clock
//   rst           in   asynchronous, active-high reset
//   log_enable    in   1 = timestamp runs and records are logged
//   detect_pls_0  in   first-pulse detect from the trigger SM
//   detect_pls_1  in   third-pulse detect from the trigger SM
//   pulse_tof     in   time-of-flight word from the trigger SM
//   evt_valid     out  FIFO head record available
//   evt_ready     in   consumer accepts the head record
//   evt_src       out  head source: bit0 = pls_0 edge, bit1 = pls_1 edge
//   evt_ts        out  head record timestamp
//   evt_tof       out  head record pulse_tof capture
//   fifo_level    out  number of stored records
//   ovf_count     out  dropped-record count, saturating at 16'hFFFF
//   ovf_sticky    out  set on any drop
//   trig_out_0    out  stretched detect_pls_0
//   trig_out_1    out  stretched detect_pls_1
// ----------------------------------------------------------------------------
module trigger_event_log #(
  parameter int FIFO_AW        = 4,
  parameter int TS_WIDTH       = 48,
  parameter int STRETCH_CYCLES = 125
) (
  input  logic                rxclk,
  input  logic                rst,
  input  logic                log_enable,
  input  logic                detect_pls_0,
  input  logic                detect_pls_1,
  input  logic [31:0]         pulse_tof,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [1:0]          evt_src,
  output logic [TS_WIDTH-1:0] evt_ts,
  output logic [31:0]         evt_tof,
  output logic [FIFO_AW:0]    fifo_level,
  output logic [15:0]         ovf_count,
  output logic                ovf_sticky,
  output logic                trig_out_0,
  output logic                trig_out_1
);

  localparam int DEPTH = 2 ** FIFO_AW;

  typedef struct packed {
    logic [1:0]          src;
    logic [TS_WIDTH-1:0] ts;
    logic [31:0]         tof;
  } rec_t;

  // --------------------------------------------------------------------------
  // Input stage: two-deep detect pipeline for edge detection. The timestamp
  // and TOF are sampled on the same edge as d_q, so a record carries the
  // values seen when the pulse was first sampled high.
  // --------------------------------------------------------------------------
  logic [1:0]          d_q;
  logic [1:0]          d_qq;
  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] ts_q;
  logic [31:0]         tof_q;
  logic                en_q;
  logic [1:0]          edge_v;
  logic                log_rise;

  assign edge_v   = d_q & ~d_qq;
  assign log_rise = log_enable & ~en_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its sources, whatever the order of the
  // statements.
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      d_q   <= '0;
      d_qq  <= '0;
      ts_q  <= '0;
      tof_q <= '0;
      en_q  <= 1'b0;
    end else begin
      d_q   <= {detect_pls_1, detect_pls_0};
      d_qq  <= d_q;
      ts_q  <= ts;
      tof_q <= pulse_tof;
      en_q  <= log_enable;
    end
  end

  // Free-running timestamp while logging. It restarts from zero when logging
  // is re-enabled and wraps silently.
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      ts <= '0;
    end else if (!log_enable || log_rise) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Write-request stage. An edge seen while logging becomes a pending record,
  // which is committed to the FIFO on the following edge. This stage sets the
  // two-cycle sample-to-valid latency. An edge that coincides with the
  // log_enable rising cycle is discarded, so a flush never races a write.
  // --------------------------------------------------------------------------
  logic wr_pend;
  rec_t wr_rec;

  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      wr_pend <= 1'b0;
      wr_rec  <= '0;
    end else begin
      wr_pend    <= log_enable & ~log_rise & (|edge_v);
      wr_rec.src <= edge_v;
      wr_rec.ts  <= ts_q;
      wr_rec.tof <= tof_q;
    end
  end

  // --------------------------------------------------------------------------
  // FWFT FIFO. The pointers carry one extra wrap bit, so full and empty can
  // be told apart without a separate counter.
  // --------------------------------------------------------------------------
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  rec_t             mem [DEPTH];
  rec_t             head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (!empty && evt_ready) pop = 1'b1;
    if (wr_pend) begin
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      if (!full || pop) push = 1'b1;
      else              drop = 1'b1;
    end
  end

  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (log_rise) begin
      // Starting a new logging session flushes the queue and clears overflow.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
      if (drop) begin
        ovf_sticky <= 1'b1;
        if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      end
    end
  end

  // NOTE: the record storage has no reset. Its contents are only visible
  // through the pointers, which are reset, and leaving the array unreset lets
  // it map onto plain RAM.
  always_ff @(posedge rxclk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= wr_rec;
  end

  assign head       = mem[rd_ptr[FIFO_AW-1:0]];
  assign evt_valid  = ~empty;
  assign fifo_level = wr_ptr - rd_ptr;

  // Gate the head fields so they read zero when there is no record, including
  // straight out of reset, before any slot has been written.
  assign evt_src = evt_valid ? head.src : '0;
  assign evt_ts  = evt_valid ? head.ts  : '0;
  assign evt_tof = evt_valid ? head.tof : '0;

  // --------------------------------------------------------------------------
  // Pulse stretchers. These run independently of log_enable. A new edge
  // reloads the counter, so a retrigger extends the output with no low glitch.
  // --------------------------------------------------------------------------
  logic [15:0] cnt [2];

  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (edge_v[i])        cnt[i] <= 16'(STRETCH_CYCLES);
        else if (cnt[i] != 0) cnt[i] <= cnt[i] - 16'd1;
      end
    end
  end

  assign trig_out_0 = (cnt[0] != 16'd0);
  assign trig_out_1 = (cnt[1] != 16'd0);

endmodule

// File: tb/tb_trigger_event_log.sv
// ----------------------------------------------------------------------------
// tb_trigger_event_log
//
// Directed bench for trigger_event_log. Inputs are driven 1 ns after each
// rising rxclk edge, and outputs are checked at that same point, once they
// have settled. The expected record timestamp is the number of rising edges
// between the log_enable rise edge and the edge just before the one that
// first samples the pulse.
// ----------------------------------------------------------------------------
module tb_trigger_event_log;

  localparam int AW  = 4;
  localparam int TSW = 48;
  localparam int SC  = 125;

  logic           rxclk = 1'b0;
  logic           rst;
  logic           log_enable;
  logic           detect_pls_0;
  logic           detect_pls_1;
  logic [31:0]    pulse_tof;
  logic           evt_valid;
  logic           evt_ready;
  logic [1:0]     evt_src;
  logic [TSW-1:0] evt_ts;
  logic [31:0]    evt_tof;
  logic [AW:0]    fifo_level;
  logic [15:0]    ovf_count;
  logic           ovf_sticky;
  logic           trig_out_0;
  logic           trig_out_1;

  trigger_event_log #(
    .FIFO_AW       (AW),
    .TS_WIDTH      (TSW),
    .STRETCH_CYCLES(SC)
  ) dut (
    .rxclk       (rxclk),
    .rst         (rst),
    .log_enable  (log_enable),
    .detect_pls_0(detect_pls_0),
    .detect_pls_1(detect_pls_1),
    .pulse_tof   (pulse_tof),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_src     (evt_src),
    .evt_ts      (evt_ts),
    .evt_tof     (evt_tof),
    .fifo_level  (fifo_level),
    .ovf_count   (ovf_count),
    .ovf_sticky  (ovf_sticky),
    .trig_out_0  (trig_out_0),
    .trig_out_1  (trig_out_1)
  );

  always #5 rxclk = ~rxclk;

  typedef struct {
    logic [1:0]     src;
    logic [TSW-1:0] ts;
    logic [31:0]    tof;
  } rec_t;

  typedef struct {
    logic [1:0]  det;
    logic [31:0] tof;
    logic [1:0]  exp_src;
  } vec_t;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   rise_cyc  = 0;
  rec_t exp_q[$];
  vec_t vecs[6];

  task automatic tick();
    @(posedge rxclk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One-cycle pulse followed by one low cycle. When the pulse is expected to
  // be logged, its record is queued in the model.
  task automatic pulse(input logic [1:0] det, input logic [31:0] tof, input bit logged);
    rec_t r;
    detect_pls_0 = det[0];
    detect_pls_1 = det[1];
    pulse_tof    = tof;
    if (logged) begin
      r.src = det;
      r.ts  = TSW'(cyc - rise_cyc);
      r.tof = tof;
      exp_q.push_back(r);
    end
    tick();
    detect_pls_0 = 1'b0;
    detect_pls_1 = 1'b0;
    pulse_tof    = ~tof;
    tick();
  endtask

  task automatic wait_pipe();
    repeat (3) tick();
  endtask

  // Compare n queued records against the FIFO head in order, popping each.
  // The last one is left in place when pop_last is 0.
  task automatic drain_check(input string name, input int n, input bit pop_last);
    rec_t e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check({name, " valid"}, 64'(evt_valid), 64'd1);
      check({name, " src"},   64'(evt_src),   64'(e.src));
      check({name, " ts"},    64'(evt_ts),    64'(e.ts));
      check({name, " tof"},   64'(evt_tof),   64'(e.tof));
      if (i < n - 1 || pop_last) begin
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got running, expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int c0;
    int c1;
    int rises;
    int c_start;
    logic prev;

    vecs = '{
      '{2'b01, 32'h0000_0011, 2'b01},
      '{2'b10, 32'h0000_0022, 2'b10},
      '{2'b11, 32'h0000_0033, 2'b11},
      '{2'b10, 32'hA5A5_5A5A, 2'b10},
      '{2'b01, 32'h8000_0001, 2'b01},
      '{2'b11, 32'hFFFF_FFFF, 2'b11}
    };

    rst          = 1'b1;
    log_enable   = 1'b0;
    detect_pls_0 = 1'b0;
    detect_pls_1 = 1'b0;
    pulse_tof    = '0;
    evt_ready    = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst evt_valid",  64'(evt_valid),  64'd0);
    check("rst fifo_level", 64'(fifo_level), 64'd0);
    check("rst ovf_count",  64'(ovf_count),  64'd0);
    check("rst ovf_sticky", 64'(ovf_sticky), 64'd0);
    check("rst trig_out",   64'({trig_out_1, trig_out_0}), 64'd0);
    check("rst evt_fields", 64'(evt_src) | 64'(evt_ts) | 64'(evt_tof), 64'd0);
    rst = 1'b0;
    tick();

    // ---------------- test 1: single pulse, latency, ts = 100 ----------------
    log_enable = 1'b1;
    tick();
    rise_cyc = cyc;
    repeat (100) tick();
    detect_pls_0 = 1'b1;
    pulse_tof    = 32'hCAFE_0001;
    tick();                          // first sampling edge
    pulse_tof = 32'h1234_5678;
    tick();
    check("t1 latency valid", 64'(evt_valid), 64'd0);
    tick();
    detect_pls_0 = 1'b0;             // held for three samples
    check("t1 valid", 64'(evt_valid), 64'd1);
    check("t1 src",   64'(evt_src),   64'd1);
    check("t1 ts",    64'(evt_ts),    64'd100);
    check("t1 tof",   64'(evt_tof),   64'hCAFE_0001);
    check("t1 level", 64'(fifo_level), 64'd1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    repeat (4) tick();
    check("t1 single record", 64'(fifo_level), 64'd0);

    // ---------------- table-driven pulse patterns ----------------
    for (int i = 0; i < 6; i++) begin
      rec_t r;
      r.src = vecs[i].exp_src;
      r.ts  = TSW'(cyc - rise_cyc);
      r.tof = vecs[i].tof;
      exp_q.push_back(r);
      detect_pls_0 = vecs[i].det[0];
      detect_pls_1 = vecs[i].det[1];
      pulse_tof    = vecs[i].tof;
      tick();
      detect_pls_0 = 1'b0;
      detect_pls_1 = 1'b0;
      pulse_tof    = 32'h0;
      tick();
    end
    wait_pipe();
    check("tbl level", 64'(fifo_level), 64'd6);
    drain_check("tbl", 6, 1'b1);

    // ---------------- test 2: coincident edges, stretch width ----------------
    repeat (SC + 5) tick();
    check("t2 idle trig", 64'({trig_out_1, trig_out_0}), 64'd0);
    pulse(2'b11, 32'h0BAD_F00D, 1'b1);
    c0 = 0;
    c1 = 0;
    // The pulse task has already used two cycles; trig_out_x is high from
    // the second of them, so count that sample first.
    if (trig_out_0) c0++;
    if (trig_out_1) c1++;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (trig_out_0) c0++;
      if (trig_out_1) c1++;
    end
    check("t2 stretch0 width", 64'(c0), 64'(SC));
    check("t2 stretch1 width", 64'(c1), 64'(SC));
    check("t2 one record", 64'(fifo_level), 64'd1);
    drain_check("t2", 1, 1'b1);

    // ---------------- test 5: retrigger at cycle 60 ----------------
    detect_pls_1 = 1'b1;
    pulse_tof    = 32'h5555_0001;
    exp_q.push_back('{2'b10, TSW'(cyc - rise_cyc), 32'h5555_0001});
    c_start = cyc;
    c1      = 0;
    rises   = 0;
    prev    = trig_out_1;
    for (int i = 0; i < 300; i++) begin
      tick();
      detect_pls_1 = 1'b0;
      if (trig_out_1) c1++;
      if (trig_out_1 && !prev) rises++;
      prev = trig_out_1;
      if (cyc == c_start + 60) begin
        detect_pls_1 = 1'b1;
        pulse_tof    = 32'h5555_0002;
        exp_q.push_back('{2'b10, TSW'(cyc - rise_cyc), 32'h5555_0002});
      end
    end
    check("t5 high cycles", 64'(c1), 64'(60 + SC));
    check("t5 no glitch", 64'(rises), 64'd1);
    check("t5 records", 64'(fifo_level), 64'd2);
    drain_check("t5", 2, 1'b1);

    // ---------------- test 3: overflow with evt_ready = 0 ----------------
    log_enable = 1'b0;
    tick();
    log_enable = 1'b1;
    tick();
    rise_cyc = cyc;
    for (int i = 0; i < 20; i++) begin
      pulse(2'b01, 32'h0000_0100 + 32'(i), i < 16);
    end
    wait_pipe();
    check("t3 level", 64'(fifo_level), 64'd16);
    check("t3 ovf_count", 64'(ovf_count), 64'd4);
    check("t3 ovf_sticky", 64'(ovf_sticky), 64'd1);
    check("t3 head ts", 64'(evt_ts), 64'(exp_q[0].ts));

    // ---------------- test 4: full FIFO, push on the pop cycle ----------------
    void'(exp_q.pop_front());
    pulse(2'b01, 32'h0000_F00D, 1'b1);
    evt_ready = 1'b1;
    tick();                          // pop and pending write on the same edge
    evt_ready = 1'b0;
    check("t4 level", 64'(fifo_level), 64'd16);
    check("t4 ovf_count", 64'(ovf_count), 64'd4);
    drain_check("t3t4 drain", 16, 1'b1);
    check("t4 drained", 64'(fifo_level), 64'd0);

    // ---------------- test 6: disable with 5 queued, then re-enable ----------------
    for (int i = 0; i < 5; i++) begin
      pulse(2'(i % 3 + 1), 32'h6600_0000 + 32'(i), 1'b1);
    end
    wait_pipe();
    log_enable = 1'b0;
    tick();
    check("t6 level", 64'(fifo_level), 64'd5);
    pulse(2'b01, 32'hDEAD_0000, 1'b0);
    wait_pipe();
    check("t6 no write when off", 64'(fifo_level), 64'd5);
    check("t6 ovf kept", 64'(ovf_count), 64'd4);
    drain_check("t6 drain", 5, 1'b0);
    check("t6 one left", 64'(fifo_level), 64'd1);

    // This edge falls on the log_enable rise cycle, so it must be discarded.
    detect_pls_0 = 1'b1;
    tick();
    log_enable = 1'b1;
    tick();
    rise_cyc     = cyc;
    detect_pls_0 = 1'b0;
    check("t6 flush level", 64'(fifo_level), 64'd0);
    check("t6 flush valid", 64'(evt_valid), 64'd0);
    check("t6 ovf_count clr", 64'(ovf_count), 64'd0);
    check("t6 ovf_sticky clr", 64'(ovf_sticky), 64'd0);
    tick();
    pulse(2'b01, 32'h7777_0001, 1'b1);
    wait_pipe();
    check("t6 rise edge discarded", 64'(fifo_level), 64'd1);
    check("t6 ts restart", 64'(evt_ts), 64'd1);
    drain_check("t6 post", 1, 1'b1);
    check("t6 final empty", 64'(evt_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
